// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multi-cycle signed restoring divider with start/done handshake
module seq_signed_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N_IN,
  input  logic [WIDTH-1:0] D_IN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q_OUT,
  output logic [WIDTH-1:0] R_OUT,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state_q, state_d;

  // |D| keeps an extra bit so the shifted partial remainder compares cleanly.
  // |N| fits WIDTH bits unsigned: the most-negative value maps to 2^(WIDTH-1).
  logic [WIDTH:0]   dmag_q, dmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_n_q, sign_n_d;
  logic             sign_q_q, sign_q_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] nmag;
  logic [WIDTH-1:0] dabs;

  // Next-state, restoring step and sign correction.
  always_comb begin
    state_d  = state_q;
    dmag_d   = dmag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sign_n_d = sign_n_q;
    sign_q_d = sign_q_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    nmag   = N_IN[WIDTH-1] ? -N_IN : N_IN;
    dabs   = D_IN[WIDTH-1] ? -D_IN : D_IN;
    rem_sh = {rem_q, quo_q[WIDTH-1]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          sign_n_d = N_IN[WIDTH-1];
          sign_q_d = N_IN[WIDTH-1] ^ D_IN[WIDTH-1];
          dmag_d   = {1'b0, dabs};
          quo_d    = nmag;
          rem_d    = '0;
          cnt_d    = CW'(WIDTH);
          dz_d     = (D_IN == '0);
          ov_d     = (N_IN == {1'b1, {(WIDTH-1){1'b0}}}) && (D_IN == '1);
        end
      end
      RUN: begin
        // With a zero divisor every step subtracts nothing, so rem ends as |N|
        // and the quotient register fills with ones.
        if (rem_sh >= dmag_q) begin
          rem_d = WIDTH'(rem_sh - dmag_q);
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_out_d = dz_q ? '1 : (sign_q_q ? -quo_q : quo_q);
        r_out_d = sign_n_q ? -rem_q : rem_q;
        dbz_d   = dz_q;
        ovf_d   = ov_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dmag_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sign_n_q <= 1'b0;
      sign_q_q <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dmag_q   <= dmag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sign_n_q <= sign_n_d;
      sign_q_q <= sign_q_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign Q_OUT = q_out_q;
  assign R_OUT = r_out_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed and table-driven bench for seq_signed_divider
module tb_seq_signed_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] N_IN = '0;
  logic [W-1:0] D_IN = '0;
  logic         busy, done, dbz, ovf;
  logic [W-1:0] Q_OUT, R_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .N_IN(N_IN), .D_IN(D_IN),
    .busy(busy), .done(done), .Q_OUT(Q_OUT), .R_OUT(R_OUT), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dz;
    int ov;
  } vec_t;

  vec_t vt[13];

  // clock generator watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after an edge where the start was sampled; c0 is the number of
  // edges already seen since (and including) that edge.
  task automatic wait_done(input int c0, output int lat, output bit stable);
    logic [W-1:0] pq, pr;
    logic pdz, pov;
    int c;
    pq = Q_OUT; pr = R_OUT; pdz = dbz; pov = ovf;
    c = c0;
    lat = -1;
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (Q_OUT !== pq || R_OUT !== pr || dbz !== pdz || ovf !== pov || busy !== 1'b1)
        stable = 1'b0;
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic run_check(input string name, input int n, input int d,
                           input int eq, input int er, input int edz, input int eov);
    int lat;
    bit stable;
    logic signed [W-1:0] q4, r4;
    q4 = eq[W-1:0];
    r4 = er[W-1:0];
    N_IN = n[W-1:0];
    D_IN = d[W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    N_IN = ~N_IN;
    D_IN = ~D_IN;
    wait_done(1, lat, stable);
    check({name, ".lat"}, lat, W + 2);
    check({name, ".q"}, $signed(Q_OUT), int'(q4));
    check({name, ".r"}, $signed(R_OUT), int'(r4));
    check({name, ".dbz"}, int'(dbz), edz);
    check({name, ".ovf"}, int'(ovf), eov);
    check({name, ".busy_done"}, int'(busy), 0);
    check({name, ".hold"}, int'(stable), 1);
  endtask

  initial begin
    int lat;
    bit stable;
    int qa, ra, seen;

    vt[0]  = '{ 7,  3,  2,  1, 0, 0};
    vt[1]  = '{-7,  3, -2, -1, 0, 0};
    vt[2]  = '{ 7, -3, -2,  1, 0, 0};
    vt[3]  = '{-7, -3,  2, -1, 0, 0};
    vt[4]  = '{ 5,  3,  1,  2, 0, 0};
    vt[5]  = '{-6,  5, -1, -1, 0, 0};
    vt[6]  = '{ 6, -5, -1,  1, 0, 0};
    vt[7]  = '{-7, -7,  1,  0, 0, 0};
    vt[8]  = '{ 0,  4,  0,  0, 0, 0};
    vt[9]  = '{ 5,  0, -1,  5, 1, 0};
    vt[10] = '{-8,  0, -1, -8, 1, 0};
    vt[11] = '{-8, -1, -8,  0, 0, 1};
    vt[12] = '{-8,  1, -8,  0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.q", int'(Q_OUT), 0);
    check("rst.r", int'(R_OUT), 0);
    check("rst.dbz", int'(dbz), 0);
    check("rst.ovf", int'(ovf), 0);

    // table vectors, each issued in the previous done cycle
    for (int i = 0; i < 13; i++) begin
      run_check($sformatf("vec%0d", i), vt[i].n, vt[i].d, vt[i].q, vt[i].r, vt[i].dz, vt[i].ov);
      if (vt[i].dz == 0 && vt[i].ov == 0) begin
        qa = $signed(Q_OUT);
        ra = $signed(R_OUT);
        check($sformatf("vec%0d.qd_plus_r", i), qa * vt[i].d + ra, vt[i].n);
        check($sformatf("vec%0d.rmag", i),
              int'((ra < 0 ? -ra : ra) < (vt[i].d < 0 ? -vt[i].d : vt[i].d)), 1);
      end
    end

    // exhaustive sweep against language division
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        if (b != 0)
          run_check($sformatf("sw_%0d_%0d", a, b), a, b, a / b, a % b, 0,
                    int'(a == -8 && b == -1));
      end
    end

    // start while busy is ignored
    @(posedge clk); #1;
    N_IN = 4'd7; D_IN = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; N_IN = 4'd3; D_IN = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; N_IN = 4'd0; D_IN = 4'd0;
    wait_done(2, lat, stable);
    check("ign.lat", lat, W + 2);
    check("ign.q", $signed(Q_OUT), 3);
    check("ign.r", $signed(R_OUT), 1);
    @(posedge clk); #1;
    check("ign.single_done", int'(done), 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("ign.no_second_op", seen, 0);
    check("ign.hold_q", $signed(Q_OUT), 3);
    check("ign.hold_r", $signed(R_OUT), 1);

    // reset in the middle of an operation
    N_IN = 4'(-7); D_IN = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.q", int'(Q_OUT), 0);
    check("midrst.r", int'(R_OUT), 0);
    check("midrst.dbz", int'(dbz), 0);
    check("midrst.ovf", int'(ovf), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("midrst.no_done", seen, 0);
    run_check("post_rst", 6, 4, 1, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
